// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, transmitter states and STATUS bit positions shared by the UART blocks
package uart_pkg;
  localparam logic [1:0] TXDATA  = 2'd0;
  localparam logic [1:0] STATUS  = 2'd1;
  localparam logic [1:0] BAUDDIV = 2'd2;
  localparam logic [1:0] CTRL    = 2'd3;
  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return d == 16'd0 ? 16'd1 : d;
  endfunction
endpackage

// File: rtl/uart_tx_periph_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; a push while full is accepted only alongside a pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign dout    = mem[rp];
  // storage is not reset; pointers and count alone define which entries are valid
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/uart_tx_periph.sv
// uart_tx_periph: bus-mapped 8N1 UART transmitter with TX FIFO; UART_TX_IRQ_EN adds the irq output and CTRL[1]
module uart_tx_periph
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int BAUD_DIV_RST = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        busWe,
  input  logic [31:0] busAddr,
  input  logic [31:0] busWData,
  output logic [31:0] busRData,
  output logic        txd
`ifdef UART_TX_IRQ_EN
  ,
  output logic        irq
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [1:0] ra;
  logic wr, push, pop, full, empty, busy, tick, ovf, tx_en, irq_rd;
  logic [CW-1:0] count;
  logic [7:0] head, shift;
  logic [15:0] bauddiv, div_eff, cnt;
  logic [2:0] bitn;
  logic [31:0] status;
  tx_state_e state, nstate;
  logic unused;
  assign unused  = ^{busAddr[31:4], busAddr[1:0], busWData[31:16]};
  assign ra      = busAddr[3:2];
  assign wr      = sel && busWe;
  assign push    = wr && ra == TXDATA;
  assign div_eff = eff_div(bauddiv);
  assign tick    = cnt == 16'd0;
  assign busy    = state != IDLE;
  assign txd     = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(busWData[7:0]),
    .dout(head), .full(full), .empty(empty), .count(count)
  );

  // next state: a frame starts only from IDLE with tx_en set and data queued; bits advance on baud ticks
  always_comb begin
    pop    = state == IDLE && tx_en && !empty;
    nstate = state == IDLE ? (pop ? START : IDLE) :
             !tick ? state :
             state == START ? DATA :
             state == DATA ? (bitn == 3'd7 ? STOP : DATA) : IDLE;
  end

  // state register; async reset aborts a frame and forces txd high at once
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nstate;

  // baud down-counter reloads from the live divisor only at bit boundaries, so divisor writes never cut a bit short
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt   <= '0;
      shift <= '0;
      bitn  <= '0;
    end else if (pop) begin
      cnt   <= div_eff - 16'd1;
      shift <= head;
      bitn  <= '0;
    end else if (busy) begin
      cnt <= tick ? div_eff - 16'd1 : cnt - 16'd1;
      if (tick && state == DATA) begin
        shift <= shift >> 1;
        bitn  <= bitn + 3'd1;
      end
    end

  // register file; a dropped push outranks a same-cycle overflow clear
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ovf     <= 1'b0;
      bauddiv <= 16'(BAUD_DIV_RST);
      tx_en   <= 1'b0;
    end else begin
      ovf <= (ovf && !(wr && ra == STATUS && busWData[ST_OVF])) || (push && full && !pop);
      if (wr && ra == BAUDDIV) bauddiv <= busWData[15:0];
      if (wr && ra == CTRL) tx_en <= busWData[0];
    end

`ifdef UART_TX_IRQ_EN
  // irq is a registered level: enabled, nothing queued and the line idle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      irq_rd <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr && ra == CTRL) irq_rd <= busWData[1];
      irq <= irq_rd && empty && !busy;
    end
`else
  assign irq_rd = 1'b0;
`endif

  // STATUS word assembly and combinational read mux
  always_comb begin
    status           = '0;
    status[ST_FULL]  = full;
    status[ST_EMPTY] = empty;
    status[ST_BUSY]  = busy;
    status[ST_OVF]   = ovf;
    status[15:8]     = 8'(count);
    busRData = !sel ? '0 :
               ra == STATUS ? status :
               ra == BAUDDIV ? {16'b0, bauddiv} :
               ra == CTRL ? {30'b0, irq_rd, tx_en} : '0;
  end
endmodule

// File: tb/tb_uart_tx_periph.sv
// tb_uart_tx_periph: randomized scoreboard bench; a line monitor decodes txd frames and checks them against queued expectations
module tb_uart_tx_periph;
  localparam logic [1:0] A_TX = 2'd0, A_ST = 2'd1, A_BD = 2'd2, A_CT = 2'd3;
  logic clk = 0, reset = 1, sel = 0, busWe = 0, txd;
  logic [31:0] busAddr = 0, busWData = 0, busRData;
`ifdef UART_TX_IRQ_EN
  logic irq;
`endif

  uart_tx_periph dut (
    .clk(clk), .reset(reset), .sel(sel), .busWe(busWe), .busAddr(busAddr),
    .busWData(busWData), .busRData(busRData), .txd(txd)
`ifdef UART_TX_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] data;
    logic [9:0][15:0] dur;
  } frame_t;
  frame_t sb[$];
  int starts[$], ends[$];
  logic [7:0] mq[$];
  logic movf = 0, mon_en = 1;
  int n_cmp = 0, n_bad = 0;

  function automatic frame_t mk(logic [7:0] d, int div_a, int div_b, int sw);
    frame_t f;
    f.data = d;
    for (int k = 0; k < 10; k++) f.dur[k] = 16'(k < sw ? div_a : div_b);
    return f;
  endfunction

  function automatic int eff(int d);
    return d == 0 ? 1 : d;
  endfunction

  function automatic logic [31:0] st_exp(int cnt, logic ovf, logic busy);
    return (32'(cnt) << 8) | {28'b0, ovf, busy, cnt == 0, cnt == 16};
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    sel = 1; busWe = 1; busAddr = {28'b0, a, 2'b0}; busWData = d;
    @(posedge clk); #1;
    sel = 0; busWe = 0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    sel = 1; busWe = 0; busAddr = {28'b0, a, 2'b0};
    #2 d = busRData;
    @(posedge clk); #1;
    sel = 0;
  endtask

  task automatic hold_byte(input logic [7:0] d);
    if (mq.size() < 16) mq.push_back(d);
    else movf = 1;
    wr(A_TX, {24'b0, d});
  endtask

  task automatic release_all(input int div);
    while (mq.size() > 0) sb.push_back(mk(mq.pop_front(), div, div, 10));
  endtask

  task automatic send(input logic [7:0] d, input int div);
    sb.push_back(mk(d, div, div, 10));
    wr(A_TX, {24'b0, d});
  endtask

  task automatic wait_idle(input string n);
    logic [31:0] s;
    int ok;
    ok = 0;
    for (int i = 0; i < 4000 && ok == 0; i++) begin
      rd(A_ST, s);
      if (s[2:1] == 2'b01) ok = 1;
    end
    chk(n, ok, 1);
  endtask

  // line monitor: every frame start pops the next expectation and checks each bit's level and length
  initial begin : monitor
    frame_t f;
    int bad;
    logic lvl;
    forever begin
      @(negedge clk);
      if (mon_en && txd === 1'b0) begin
        if (sb.size() == 0) begin
          chk("unexpected_frame", 1, 0);
          while (txd === 1'b0) @(negedge clk);
        end else begin
          f = sb.pop_front();
          starts.push_back(cyc);
          for (int k = 0; k < 10; k++) begin
            lvl = k == 0 ? 1'b0 : k == 9 ? 1'b1 : f.data[k-1];
            bad = 0;
            for (int c = 0; c < int'(f.dur[k]); c++) begin
              if (k != 0 || c != 0) @(negedge clk);
              if (txd !== lvl) bad++;
            end
            chk($sformatf("frame_%02h_bit%0d_bad_cycles", f.data, k), bad, 0);
          end
          ends.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] s;
    logic [7:0] b;
    int w, d;
    #1 chk("reset_txd", txd, 1);
`ifdef UART_TX_IRQ_EN
    chk("reset_irq", irq, 0);
`endif
    repeat (2) @(posedge clk);
    #1 reset = 0;
    rd(A_ST, s); chk("rst_status", s, st_exp(0, 0, 0));
    rd(A_BD, s); chk("rst_bauddiv", s, 868);
    rd(A_CT, s); chk("rst_ctrl", s, 0);
    busAddr = 32'h8;
    #1 chk("unselected_read", busRData, 0);
    rd(A_TX, s); chk("txdata_read", s, 0);

    wr(A_BD, 4); wr(A_CT, 1);
    starts.delete(); ends.delete();
    send(8'hA5, 4);
    w = cyc;
    repeat (2) @(posedge clk);
    #1 rd(A_ST, s); chk("t1_busy", s, st_exp(0, 0, 1));
    wait_idle("t1_idle");
    chk("t1_latency", starts[0] - w, 1);
    chk("t1_length", ends[0] - starts[0], 39);

    wr(A_CT, 0);
    for (int i = 0; i < 17; i++) hold_byte(8'($urandom));
    rd(A_ST, s); chk("t2_full_ovf", s, st_exp(mq.size(), movf, 0));
    wr(A_ST, 32'h8);
    movf = 0;
    rd(A_ST, s); chk("t2_ovf_clear", s, st_exp(mq.size(), movf, 0));
    wr(A_BD, 1);
    release_all(1);
    wr(A_CT, 1);
    b = 8'($urandom);
    send(b, 1);
    rd(A_ST, s); chk("t2_push_pop_full", s, st_exp(16, 0, 1));
    wait_idle("t2_idle");

    wr(A_CT, 0); wr(A_BD, 3);
    for (int i = 0; i < 3; i++) hold_byte(8'($urandom));
    release_all(3);
    starts.delete(); ends.delete();
    wr(A_CT, 1);
    wait_idle("t3_idle");
    chk("t3_frames", starts.size(), 3);
    for (int i = 1; i < starts.size(); i++) chk("t3_gap", starts[i] - ends[i-1], 2);
    rd(A_ST, s); chk("t3_empty", s, st_exp(0, 0, 0));

    wr(A_BD, 4);
    starts.delete(); ends.delete();
    b = 8'($urandom);
    sb.push_back(mk(b, 4, 8, 4));
    wr(A_TX, {24'b0, b});
    repeat (13) @(posedge clk);
    #1 wr(A_BD, 8);
    wait_idle("t4_idle");
    chk("t4_length", ends[0] - starts[0], 63);

    wr(A_BD, 4);
    mon_en = 0;
    wr(A_TX, 0);
    repeat (10) @(posedge clk);
    #3 chk("t5_pre_reset_txd", txd, 0);
    reset = 1;
    #1 chk("t5_async_txd", txd, 1);
    @(posedge clk);
    #1 reset = 0;
    mq.delete();
    movf = 0;
    rd(A_ST, s); chk("t5_status", s, st_exp(0, 0, 0));
    rd(A_BD, s); chk("t5_bauddiv", s, 868);
    rd(A_CT, s); chk("t5_ctrl", s, 0);
    mon_en = 1;

    wr(A_CT, 1);
    for (int r = 0; r < 3; r++) begin
      d = r == 0 ? 0 : int'($urandom_range(1, 3));
      wr(A_BD, d);
      for (int i = 0; i < 4; i++) begin
        send(8'($urandom), eff(d));
        repeat ($urandom_range(0, 5)) @(posedge clk);
        #1;
      end
      wait_idle("rand_idle");
    end

`ifdef UART_TX_IRQ_EN
    wr(A_CT, 0); wr(A_BD, 2);
    ends.delete();
    send(8'($urandom), 2);
    chk("t6_irq_low", irq, 0);
    wr(A_CT, 3);
    rd(A_CT, s); chk("t6_ctrl", s, 3);
    w = -1;
    for (int i = 0; i < 200 && w < 0; i++) begin
      @(negedge clk);
      if (irq === 1'b1) w = cyc;
    end
    chk("t6_irq_rise", w - ends[0], 2);
    @(posedge clk);
    #1 send(8'($urandom), 2);
    chk("t6_irq_hold", irq, 1);
    @(posedge clk);
    #1 chk("t6_irq_drop", irq, 0);
    wait_idle("t6_idle");
`else
    wr(A_CT, 3);
    rd(A_CT, s); chk("ctrl_irq_en_ignored", s, 1);
`endif

    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
